// File: rtl/wishbone_to_ahb.sv
// Wishbone classic slave to AHB-Lite master bridge: one single-beat transfer at a time,
// with byte-lane selects translated to AHB size and low address bits.
module wishbone_to_ahb #(
   parameter int          ADDR_WIDTH = 32,
   parameter int          DATA_WIDTH = 32,
   parameter logic [3:0]  HPROT_VAL  = 4'b0011
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wb_cyc,
   input  logic                      wb_stb,
   input  logic                      wb_we,
   input  logic [DATA_WIDTH/8-1:0]   wb_sel,
   input  logic [ADDR_WIDTH-1:0]     wb_adr,
   input  logic [DATA_WIDTH-1:0]     wb_dat_w,
   output logic [DATA_WIDTH-1:0]     wb_dat_r,
   output logic                      wb_ack,
   output logic                      wb_err,
   output logic [ADDR_WIDTH-1:0]     HADDR,
   output logic [1:0]                HTRANS,
   output logic                      HWRITE,
   output logic [2:0]                HSIZE,
   output logic [2:0]                HBURST,
   output logic [3:0]                HPROT,
   output logic                      HMASTLOCK,
   output logic [DATA_WIDTH-1:0]     HWDATA,
   input  logic [DATA_WIDTH-1:0]     HRDATA,
   input  logic                      HREADY,
   input  logic                      HRESP
);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, ACK, ERR} state_t;

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;

   state_t                  state_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [1:0]              trans_q;
   logic                    write_q;
   logic [2:0]              size_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic                    ack_q;
   logic                    err_q;
   logic                    abort_q;

   logic                    selLegal_d;
   logic [2:0]              selSize_d;
   logic [1:0]              selOffset_d;
   logic [ADDR_WIDTH-1:0]   addr_d;

   always_comb begin
      selLegal_d  = 1'b1;
      selSize_d   = 3'b010;
      selOffset_d = 2'b00;
      case (wb_sel)
         4'b1111: ;
         4'b0011: selSize_d = 3'b001;
         4'b1100: begin selSize_d = 3'b001; selOffset_d = 2'b10; end
         4'b0001: selSize_d = 3'b000;
         4'b0010: begin selSize_d = 3'b000; selOffset_d = 2'b01; end
         4'b0100: begin selSize_d = 3'b000; selOffset_d = 2'b10; end
         4'b1000: begin selSize_d = 3'b000; selOffset_d = 2'b11; end
         default: selLegal_d = 1'b0;
      endcase
      // The byte offset comes from the lane selects, never from the master's low address bits.
      addr_d = (wb_adr & ~ADDR_WIDTH'(3)) | ADDR_WIDTH'(selOffset_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         trans_q <= TRANS_IDLE;
         write_q <= 1'b0;
         size_q  <= 3'b000;
         wdata_q <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (wb_cyc && wb_stb) begin
                  addr_q  <= addr_d;
                  write_q <= wb_we;
                  size_q  <= selSize_d;
                  wdata_q <= wb_dat_w;
                  abort_q <= 1'b0;
                  if (selLegal_d) begin
                     trans_q <= TRANS_NONSEQ;
                     state_q <= ADDR;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= ERR;
                  end
               end
            end
            ADDR: begin
               if (!wb_cyc) abort_q <= 1'b1;
               if (HREADY) begin
                  trans_q <= TRANS_IDLE;
                  state_q <= DATA;
               end
            end
            DATA: begin
               // An abandoned cycle still finishes on AHB but earns no Wishbone response.
               if (HREADY) begin
                  if (abort_q || !wb_cyc) begin
                     state_q <= IDLE;
                  end else if (HRESP) begin
                     err_q   <= 1'b1;
                     state_q <= ERR;
                  end else begin
                     if (!write_q) rdata_q <= HRDATA;
                     ack_q   <= 1'b1;
                     state_q <= ACK;
                  end
               end else if (!wb_cyc) begin
                  abort_q <= 1'b1;
               end
            end
            ACK:     state_q <= IDLE;
            ERR:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign HADDR     = addr_q;
   assign HTRANS    = trans_q;
   assign HWRITE    = write_q;
   assign HSIZE     = size_q;
   assign HWDATA    = wdata_q;
   assign wb_dat_r  = rdata_q;
   assign wb_ack    = ack_q;
   assign wb_err    = err_q;
   assign HBURST    = 3'b000;
   assign HPROT     = HPROT_VAL;
   assign HMASTLOCK = 1'b0;

endmodule
